// File: rtl/ram_pkg.sv
// Shared types and elaboration-time helpers for the synchronous RAM bank.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ram_pkg;

   // Bank sequencing: clear every word after reset, then serve requests
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Number of byte lanes in a data word
   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

   // Legal parameter set: whole bytes per word, and DEPTH fits in the address space
   function automatic bit params_ok(input int data_w, input int addr_w, input int depth);
      return (data_w > 0) && (data_w % 8 == 0) && (depth >= 1) &&
             (longint'(depth) <= (longint'(1) << addr_w));
   endfunction

endpackage

// File: rtl/ram_sync_array.sv
// Byte-writable word storage with a registered read port; no reset on contents.
// Latency: read data valid the cycle after re; writes land at the clock edge.
// Backpressure: none; rdata holds its value while re is low.
module ram_sync_array
   import ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int BE_W   = be_w(DATA_W)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [BE_W-1:0]   be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Per-byte write; caller guarantees addr < DEPTH whenever we or re is set
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we && be[i]) begin
            mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Read register only moves on a read so a stalled response stays stable
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_sync_bank.sv
// Single-port RAM bank with valid/ready request and response channels and post-reset clear.
// Latency: read response one cycle after acceptance; writes produce no response.
// Backpressure: req_ready drops while a response is stalled, so nothing overtakes a held read.
module ram_sync_bank
   import ram_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 256,
   parameter int INIT_CLEAR = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W/8-1:0]    req_be,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic                   init_busy
);

   localparam int                BE_W      = be_w(DATA_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   if (!params_ok(DATA_W, ADDR_W, DEPTH)) begin : g_param_check
      $error("ram_sync_bank: DATA_W must be a multiple of 8 and 1 <= DEPTH <= 2**ADDR_W");
   end

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;

   logic              in_range;
   logic              accept;
   logic              rd_acc;
   logic              wr_acc;

   logic              arr_we;
   logic              arr_re;
   logic [BE_W-1:0]   arr_be;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;

   // Handshake, range check and array port steering (clear sequencer owns the port in INIT)
   always_comb begin
      in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
      req_ready = (state_q == ST_RUN) && !rst && (!rsp_valid_q || rsp_ready);
      accept    = req_valid && req_ready;
      rd_acc    = accept && !req_we;
      wr_acc    = accept && req_we && in_range;

      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_be    = req_be;
      arr_addr  = req_addr;
      arr_wdata = req_wdata;
      if (state_q == ST_INIT) begin
         arr_we    = !rst;
         arr_be    = {BE_W{1'b1}};
         arr_addr  = clr_cnt_q;
         arr_wdata = '0;
      end else begin
         arr_we = wr_acc;
         arr_re = rd_acc && in_range;
      end
   end

   // Next-state: clear counter walk, then response register load/drain
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;

      if (state_q == ST_INIT) begin
         clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         if (clr_cnt_q == LAST_ADDR) begin
            clr_cnt_d = '0;
            state_d   = ST_RUN;
         end
      end

      if (rd_acc) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = !in_range;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // FSM and response state; reset discards any pending response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
         clr_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   ram_sync_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .BE_W   (BE_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .re    (arr_re),
      .be    (arr_be),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Out-of-range reads and idle cycles present zero data
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_valid_q && rsp_err_q;
   assign rsp_rdata = (rsp_valid_q && !rsp_err_q) ? arr_rdata : '0;
   assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_ram_sync_bank.sv
// Drives a DEPTH=256 and a DEPTH=200 bank with shared stimulus and checks both
// against a word-array reference every cycle, plus directed literal expectations.
module tb_ram_sync_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;

   logic [1:0]  rdy;
   logic [1:0]  vld;
   logic [1:0]  err;
   logic [1:0]  busy;
   logic [31:0] rdata_o [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_sync_bank #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .INIT_CLEAR(1)) u_dut256 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(vld[0]),
      .rsp_ready(rsp_ready), .rsp_rdata(rdata_o[0]), .rsp_err(err[0]), .init_busy(busy[0]));

   ram_sync_bank #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .INIT_CLEAR(1)) u_dut200 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(vld[1]),
      .rsp_ready(rsp_ready), .rsp_rdata(rdata_o[1]), .rsp_err(err[1]), .init_busy(busy[1]));

   // ---------------- reference model ----------------
   int          dep [2] = '{256, 200};
   logic [31:0] mdl_mem [2][256];
   int          init_left [2] = '{256, 200};
   bit          pv [2] = '{1'b0, 1'b0};
   logic [31:0] pd [2];
   bit          pe [2];
   bit          chk_en = 1'b0;

   typedef struct { logic [31:0] d; logic e; } rsp_t;
   rsp_t got0 [$];
   rsp_t got1 [$];

   function automatic bit exp_rdy(int k);
      return !rst && (init_left[k] == 0) && (!pv[k] || rsp_ready);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            init_left[k] = dep[k];
            pv[k] = 1'b0;
            for (int a = 0; a < 256; a++) mdl_mem[k][a] = '0;
            chk_en = 1'b1;
         end else if (init_left[k] > 0) begin
            init_left[k]--;
         end else begin
            bit acc;
            acc = req_valid && exp_rdy(k);
            if (acc && req_we && (int'(req_addr) < dep[k])) begin
               for (int b = 0; b < 4; b++)
                  if (req_be[b]) mdl_mem[k][req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
            end
            if (acc && !req_we) begin
               pv[k] = 1'b1;
               pe[k] = !(int'(req_addr) < dep[k]);
               pd[k] = pe[k] ? 32'h0 : mdl_mem[k][req_addr];
            end else if (pv[k] && rsp_ready) begin
               pv[k] = 1'b0;
            end
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired, got no event expected one", name);
   endtask

   // Per-cycle comparison against the model; also record delivered responses
   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc%0d req_ready", k), rdy[k], exp_rdy(k));
            check($sformatf("cyc%0d init_busy", k), busy[k], init_left[k] > 0);
            check($sformatf("cyc%0d rsp_valid", k), vld[k], pv[k]);
            if (pv[k]) begin
               check($sformatf("cyc%0d rsp_rdata", k), rdata_o[k], pd[k]);
               check($sformatf("cyc%0d rsp_err", k), err[k], pe[k]);
            end
         end
         if (vld[0] && rsp_ready) got0.push_back('{rdata_o[0], err[0]});
         if (vld[1] && rsp_ready) got1.push_back('{rdata_o[1], err[1]});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(bit we, logic [7:0] a, logic [3:0] be, logic [31:0] d);
      int waited;
      waited = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = d;
      forever begin
         #1;
         if (rdy[0] && rdy[1]) break;
         @(negedge clk);
         waited++;
         if (waited > 60) begin
            timeout_fail("send");
            break;
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic idle(int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_expect(int k, logic [31:0] d, logic e, string name);
      rsp_t r;
      if (k == 0) begin
         check({name, " present"}, got0.size() > 0, 1'b1);
         if (got0.size() == 0) return;
         r = got0.pop_front();
      end else begin
         check({name, " present"}, got1.size() > 0, 1'b1);
         if (got1.size() == 0) return;
         r = got1.pop_front();
      end
      check({name, " rdata"}, r.d, d);
      check({name, " err"}, r.e, e);
   endtask

   task automatic wait_init(string name);
      int n;
      n = 0;
      while (busy[0] || busy[1]) begin
         @(negedge clk);
         n++;
         if (n > 400) begin
            timeout_fail(name);
            break;
         end
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int c0, c1;
      logic [31:0] held;

      // reset values
      repeat (3) @(negedge clk);
      #2;
      check("reset req_ready", rdy[0], 1'b0);
      check("reset rsp_valid", vld[0], 1'b0);
      check("reset rsp_rdata", rdata_o[0], 32'h0);
      check("reset rsp_err", err[0], 1'b0);
      check("reset init_busy", busy[0], 1'b1);

      // clear sequence length
      @(negedge clk);
      rst = 1'b0;
      c0 = 0; c1 = 0;
      for (int c = 0; c < 300; c++) begin
         #2;
         if (busy[0]) c0++;
         if (busy[1]) c1++;
         @(negedge clk);
      end
      check("init cycles 256", c0, 256);
      check("init cycles 200", c1, 200);

      send(0, 8'h00, 4'h0, 32'h0);
      send(0, 8'hFF, 4'h0, 32'h0);
      idle(3);
      pop_expect(0, 32'h0, 1'b0, "t1 rd00 d256");
      pop_expect(0, 32'h0, 1'b0, "t1 rdFF d256");
      pop_expect(1, 32'h0, 1'b0, "t1 rd00 d200");
      pop_expect(1, 32'h0, 1'b1, "t1 rdFF d200");

      // byte enables
      send(1, 8'h10, 4'b1111, 32'hDEADBEEF);
      send(1, 8'h10, 4'b0101, 32'h11223344);
      send(1, 8'h10, 4'b0000, 32'hFFFFFFFF);
      send(0, 8'h10, 4'h0, 32'h0);
      idle(3);
      pop_expect(0, 32'hDE22BE44, 1'b0, "t2 be d256");
      pop_expect(1, 32'hDE22BE44, 1'b0, "t2 be d200");

      // read-after-write, one-cycle latency
      send(1, 8'h20, 4'hF, 32'hA5A5A5A5);
      send(0, 8'h20, 4'h0, 32'h0);
      #2;
      check("t3 rsp_valid", vld[0], 1'b1);
      check("t3 rsp_rdata", rdata_o[0], 32'hA5A5A5A5);
      @(negedge clk);
      idle(2);
      got0.delete(); got1.delete();

      // range check on DEPTH=200
      send(1, 8'hC7, 4'hF, 32'h12345678);
      send(1, 8'hC8, 4'hF, 32'hFFFFFFFF);
      send(0, 8'hC8, 4'h0, 32'h0);
      send(0, 8'hC7, 4'h0, 32'h0);
      idle(3);
      pop_expect(1, 32'h0, 1'b1, "t4 rdC8 d200");
      pop_expect(1, 32'h12345678, 1'b0, "t4 rdC7 d200");
      pop_expect(0, 32'hFFFFFFFF, 1'b0, "t4 rdC8 d256");
      pop_expect(0, 32'h12345678, 1'b0, "t4 rdC7 d256");

      // stalled consumer
      send(1, 8'h01, 4'hF, 32'h10000001);
      send(1, 8'h02, 4'hF, 32'h10000002);
      send(1, 8'h03, 4'hF, 32'h10000003);
      rsp_ready = 1'b0;
      fork
         begin
            send(0, 8'h01, 4'h0, 32'h0);
            send(0, 8'h02, 4'h0, 32'h0);
            send(0, 8'h03, 4'h0, 32'h0);
         end
         begin
            int n;
            n = 0;
            forever begin
               @(negedge clk);
               #1;
               if (vld[0]) break;
               n++;
               if (n > 20) begin
                  timeout_fail("t5 first rsp");
                  break;
               end
            end
            held = rdata_o[0];
            for (int i = 0; i < 3; i++) begin
               check("t5 held rdata", rdata_o[0], 32'h10000001);
               check("t5 held stable", rdata_o[0], held);
               check("t5 held req_ready", rdy[0], 1'b0);
               if (i < 2) begin
                  @(negedge clk);
                  #1;
               end
            end
            @(negedge clk);
            rsp_ready = 1'b1;
         end
      join
      idle(4);
      pop_expect(0, 32'h10000001, 1'b0, "t5 r1");
      pop_expect(0, 32'h10000002, 1'b0, "t5 r2");
      pop_expect(0, 32'h10000003, 1'b0, "t5 r3");
      check("t5 no extra", got0.size(), 0);
      got1.delete();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int sel;
         sel = $urandom_range(0, 3);
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = $urandom_range(0, 1);
         case (sel)
            0, 1:    req_addr = 8'($urandom_range(0, 15));
            2:       req_addr = 8'($urandom_range(190, 210));
            default: req_addr = 8'($urandom_range(0, 255));
         endcase
         req_be    = 4'($urandom_range(0, 15));
         req_wdata = $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      idle(5);
      got0.delete(); got1.delete();

      // reset with a stalled response and a pending request
      send(1, 8'h30, 4'hF, 32'hCAFEF00D);
      rsp_ready = 1'b0;
      send(0, 8'h30, 4'h0, 32'h0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h31;
      rst = 1'b1;
      @(negedge clk);
      #2;
      check("t6 rsp_valid after rst", vld[0], 1'b0);
      check("t6 init_busy after rst", busy[0], 1'b1);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_init("t6 init");
      send(0, 8'h30, 4'h0, 32'h0);
      idle(3);
      pop_expect(0, 32'h0, 1'b0, "t6 cleared d256");
      pop_expect(1, 32'h0, 1'b0, "t6 cleared d200");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
